// File: rtl/ddr_out.sv
// I/Q frame serializer feeding a 2-bit ODDR pair: 32-bit frames, 16 cycles each, one-entry input buffer.
// Optional saturating underrun counter port enabled by DDR_OUT_UNDERRUN_CNT_EN.
module ddr_out (
   input  logic        clk,
   input  logic        rst_ddr_n,
   input  logic        tx_en,
   input  logic [12:0] data_i,
   input  logic [12:0] data_q,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        data_rise,
   output logic        data_fall,
   output logic        frame_start,
   output logic        tx_active,
`ifdef DDR_OUT_UNDERRUN_CNT_EN
   output logic        underrun,
   output logic [15:0] underrun_cnt
`else
   output logic        underrun
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [31:0] sh, sh_nxt;
   logic [3:0]  slot, slot_nxt;
   logic [12:0] hold_i, hold_q;
   logic        hold_v;
   logic        load, starve, consume, accept;

   function automatic logic [31:0] mk_frame(input logic [12:0] i, input logic [12:0] q);
      return {2'b10, i, 1'b0, 2'b01, q, 1'b0};
   endfunction

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      slot_nxt  = slot;
      load      = 1'b0;
      starve    = 1'b0;
      case (state)
         IDLE: begin
            sh_nxt   = '0;
            slot_nxt = '0;
            if (tx_en && hold_v) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (slot == 4'd15) begin
               // A frame always runs to slot 15; tx_en is only looked at on the boundary.
               if (tx_en) begin
                  load   = 1'b1;
                  starve = !hold_v;
               end else begin
                  state_nxt = IDLE;
                  sh_nxt    = '0;
                  slot_nxt  = '0;
               end
            end else begin
               sh_nxt   = {sh[29:0], 2'b00};
               slot_nxt = slot + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         sh_nxt   = hold_v ? mk_frame(hold_i, hold_q) : mk_frame(13'd0, 13'd0);
         slot_nxt = '0;
      end
   end

   assign consume    = load && hold_v;
   assign data_ready = !hold_v || consume;
   assign accept     = data_valid && data_ready;
   assign data_rise  = sh[31];
   assign data_fall  = sh[30];
   assign tx_active  = (state == RUN);

   always_ff @(posedge clk) begin
      if (!rst_ddr_n) begin
         state       <= IDLE;
         sh          <= '0;
         slot        <= '0;
         hold_v      <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         state       <= state_nxt;
         sh          <= sh_nxt;
         slot        <= slot_nxt;
         frame_start <= load;
         underrun    <= starve;
         // Accept wins over consume so a same-cycle refill keeps the buffer full.
         if (accept) begin
            hold_i <= data_i;
            hold_q <= data_q;
            hold_v <= 1'b1;
         end else if (consume) begin
            hold_v <= 1'b0;
         end
      end
   end

`ifdef DDR_OUT_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_ddr_n)
         underrun_cnt <= '0;
      else if (starve && underrun_cnt != 16'hFFFF)
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ddr_out.sv
// Bench for ddr_out: frame-word table, hand-written corner sequences, and random traffic against a frame-level model.
module tb_ddr_out;

   logic        clk = 1'b0;
   logic        rst_ddr_n, tx_en, data_valid;
   logic [12:0] data_i, data_q;
   logic        data_ready, data_rise, data_fall, frame_start, tx_active, underrun;
`ifdef DDR_OUT_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   always #5 clk = ~clk;

   ddr_out dut (
      .clk(clk), .rst_ddr_n(rst_ddr_n), .tx_en(tx_en),
      .data_i(data_i), .data_q(data_q), .data_valid(data_valid),
      .data_ready(data_ready), .data_rise(data_rise), .data_fall(data_fall),
      .frame_start(frame_start), .tx_active(tx_active),
`ifdef DDR_OUT_UNDERRUN_CNT_EN
      .underrun(underrun), .underrun_cnt(underrun_cnt)
`else
      .underrun(underrun)
`endif
   );

   int total = 0, bad = 0, ur_seen = 0, cyc = 0;

   // Frame-level model: current word plus slot index, buffered sample, pulses.
   bit          m_run, m_hv, m_fs, m_ur;
   int          m_slot, m_cnt;
   logic [31:0] m_word;
   logic [12:0] m_hi, m_hq;

   typedef struct {
      logic [12:0] i;
      logic [12:0] q;
      logic [31:0] word;
   } vec_t;
   vec_t tbl[4];

   function automatic logic [31:0] frame_of(input logic [12:0] i, input logic [12:0] q);
      return {2'b10, i, 1'b0, 2'b01, q, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit m_load();
      return (!m_run && tx_en && m_hv) || (m_run && m_slot == 15 && tx_en);
   endfunction

   function automatic bit m_ready();
      return !m_hv || (m_load() && m_hv);
   endfunction

   task automatic model_step();
      bit ld, rdy;
      ld  = m_load();
      rdy = m_ready();
      if (!rst_ddr_n) begin
         m_run = 0; m_slot = 0; m_word = '0; m_hv = 0; m_fs = 0; m_ur = 0; m_cnt = 0;
      end else begin
         m_fs = ld;
         m_ur = ld && !m_hv;
         if (m_ur && m_cnt < 65535) m_cnt++;
         if (ld) begin
            m_word = m_hv ? frame_of(m_hi, m_hq) : frame_of(13'd0, 13'd0);
            m_run  = 1;
            m_slot = 0;
         end else if (m_run) begin
            if (m_slot == 15) begin
               m_run = 0; m_slot = 0;
            end else m_slot++;
         end
         if (data_valid && rdy) begin
            m_hi = data_i; m_hq = data_q; m_hv = 1;
         end else if (ld && m_hv) m_hv = 0;
      end
   endtask

   task automatic check_model();
      chk("ready", data_ready, m_ready());
      chk("rise", data_rise, m_run ? m_word[31 - 2*m_slot] : 1'b0);
      chk("fall", data_fall, m_run ? m_word[30 - 2*m_slot] : 1'b0);
      chk("frame_start", frame_start, m_fs);
      chk("tx_active", tx_active, m_run);
      chk("underrun", underrun, m_ur);
`ifdef DDR_OUT_UNDERRUN_CNT_EN
      chk("underrun_cnt", underrun_cnt, m_cnt[15:0]);
`endif
   endtask

   task automatic tick();
      #1;
      check_model();
      if (underrun === 1'b1) ur_seen++;
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_ddr_n = 0;
      tick();
      rst_ddr_n = 1;
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      while (frame_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("wait_frame_start_timeout", 0, 1);
   endtask

   task automatic collect(output logic [31:0] w);
      w = '0;
      for (int i = 0; i < 16; i++) begin
         w = {w[29:0], data_rise, data_fall};
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int          lat, n, fs_cnt, last_fs;

      tbl[0] = '{13'h0ABC, 13'h1234, 32'h9578_6468};
      tbl[1] = '{13'h0000, 13'h0000, 32'h8000_4000};
      tbl[2] = '{13'h1FFF, 13'h1FFF, 32'hBFFE_7FFE};
      tbl[3] = '{13'h1000, 13'h0001, 32'hA000_4002};

      rst_ddr_n = 0; tx_en = 0; data_valid = 0; data_i = '0; data_q = '0;
      @(posedge clk);
      model_step();
      #1;
      tick();
      rst_ddr_n = 1;
      #1;
      chk("reset_ready", data_ready, 1);
      chk("reset_outputs", {tx_active, data_rise, data_fall, frame_start, underrun}, 0);

      // Frame contents and handshake-to-frame_start latency.
      foreach (tbl[k]) begin
         do_reset();
         tx_en = 1; data_valid = 1; data_i = tbl[k].i; data_q = tbl[k].q;
         tick();
         data_valid = 0;
         lat = 1;
         while (frame_start !== 1'b1 && lat < 40) begin
            tick();
            lat++;
         end
         chk("latency", lat, 2);
         tx_en = 0;
         collect(w);
         chk("frame_word", w, tbl[k].word);
         chk("idle_after_frame", {tx_active, data_rise, data_fall}, 0);
      end

      // Continuous supply: back-to-back frames every 16 cycles, no underrun.
      do_reset();
      ur_seen = 0; fs_cnt = 0; last_fs = -1;
      tx_en = 1; data_valid = 1;
      for (int i = 0; i < 70; i++) begin
         data_i = 13'($urandom); data_q = 13'($urandom);
         if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("fs_gap", cyc - last_fs, 16);
            last_fs = cyc;
            fs_cnt++;
         end
         tick();
      end
      chk("fs_count_ge4", fs_cnt >= 4, 1);
      chk("no_underrun_stream", ur_seen, 0);
      tx_en = 0; data_valid = 0;
      for (int i = 0; i < 20; i++) tick();

      // Starvation: idle frames and one underrun pulse per starved frame.
      do_reset();
      ur_seen = 0;
      tx_en = 1; data_valid = 1; data_i = 13'($urandom); data_q = 13'($urandom);
      tick();
      data_valid = 0;
      wait_fs(n);
      collect(w);
      collect(w);
      chk("starved_word1", w, 32'h8000_4000);
      collect(w);
      chk("starved_word2", w, 32'h8000_4000);
      tx_en = 0;
      collect(w);
      chk("starved_pulses", ur_seen, 3);
      chk("starved_stopped", tx_active, 0);
`ifdef DDR_OUT_UNDERRUN_CNT_EN
      chk("cnt_three", underrun_cnt, 16'd3);
      force dut.underrun_cnt = 16'hFFFE;
      #1;
      release dut.underrun_cnt;
      m_cnt = 65534;
      tx_en = 1; data_valid = 1;
      tick();
      data_valid = 0;
      wait_fs(n);
      collect(w);
      collect(w);
      tx_en = 0;
      collect(w);
      chk("cnt_saturated", underrun_cnt, 16'hFFFF);
`endif

      // tx_en dropped at slot 5: the frame still runs all 16 slots.
      do_reset();
      tx_en = 1; data_valid = 1; data_i = 13'h0555; data_q = 13'h0AAA;
      tick();
      data_valid = 0;
      wait_fs(n);
      for (int i = 0; i < 5; i++) tick();
      tx_en = 0;
      n = 0;
      while (tx_active === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("slots_after_drop", n, 11);
      chk("drop_outputs_zero", {tx_active, data_rise, data_fall}, 0);

      // Reset at slot 8 with a sample buffered: abort and discard.
      do_reset();
      tx_en = 1; data_valid = 1; data_i = 13'h1FFF; data_q = 13'h1FFF;
      tick();
      wait_fs(n);
      data_valid = 0;
      for (int i = 0; i < 8; i++) tick();
      rst_ddr_n = 0;
      tick();
      rst_ddr_n = 1;
      #1;
      chk("midreset_outputs", {tx_active, data_rise, data_fall, frame_start}, 0);
      chk("midreset_ready", data_ready, 1);
      tick();
      tick();
      chk("midreset_stays_idle", tx_active, 0);

      // Random traffic against the model.
      tx_en = 1;
      for (int i = 0; i < 3000; i++) begin
         rst_ddr_n  = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
         data_valid = ($urandom_range(0, 3) != 0);
         data_i     = 13'($urandom);
         data_q     = 13'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
